// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- multicycle ALU for the Mini-SRC datapath.
//
// One operation per accepted start. Single-cycle ops (ADD, SUB, shifts,
// rotates, AND, OR, NEG, NOT, and the inc_pc increment) register their value
// into `result` on the accept edge. Signed MUL (shift-add on magnitudes) and
// signed DIV (restoring, on magnitudes) iterate one bit per clock. When they
// finish they write HI/LO. They never touch `result`.
//
// Ports
//   clock     rising-edge clock
//   clear     asynchronous, active-low reset
//   start     launch an op (sampled only in IDLE)
//   op[4:0]   operation code
//   inc_pc    with start: result = a + PC_INC, overrides op
//   a, b      operands (WIDTH bits)
//   result    registered single-cycle result
//   hi, lo    MUL product high/low word, or DIV remainder/quotient
//   busy      high while MUL or DIV is iterating
//   done      one-cycle pulse when the outputs of an op are updated
//   div_zero  last accepted op was DIV with b == 0
//   illegal   last accepted op code was undefined
//   state_dbg current FSM state (IDLE=0, MULT=1, DIVD=2)
//
// Handshake: start is taken only when the FSM is in IDLE. The edge that takes it
// is the accept edge. busy is high in every cycle the FSM spends in MULT or DIVD.
// done is high for exactly one cycle, and the outputs are already valid in that
// cycle. A start held in the done cycle is taken on the next edge. A start seen
// while busy is dropped. It is not queued.
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH  = 32,
  parameter int PC_INC = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic             inc_pc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             illegal,
  output logic [1:0]       state_dbg
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_SHR  = 5'h05;
  localparam logic [4:0] OP_SHRA = 5'h06;
  localparam logic [4:0] OP_SHL  = 5'h07;
  localparam logic [4:0] OP_ROR  = 5'h08;
  localparam logic [4:0] OP_ROL  = 5'h09;
  localparam logic [4:0] OP_AND  = 5'h0A;
  localparam logic [4:0] OP_OR   = 5'h0B;
  localparam logic [4:0] OP_MUL  = 5'h0F;
  localparam logic [4:0] OP_DIV  = 5'h10;
  localparam logic [4:0] OP_NEG  = 5'h11;
  localparam logic [4:0] OP_NOT  = 5'h12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIVD = 2'd2
  } state_t;

  state_t state, state_next;

  // iteration registers shared by MUL and DIV
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] work_hi;   // MUL partial product high / DIV partial remainder
  logic [WIDTH-1:0] work_lo;   // MUL multiplier->product low / DIV dividend->quotient
  logic [WIDTH-1:0] opnd;      // MUL |multiplicand| / DIV |divisor|
  logic             neg_q;     // negate product / quotient at the end
  logic             neg_r;     // negate remainder at the end (dividend sign)

  logic             last;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] alu_val;
  logic             alu_ok;
  logic [2*WIDTH-1:0] dbl, rol_full, ror_full;

  logic [WIDTH:0]     mul_add, mul_sum;
  logic [WIDTH-1:0]   mul_hi, mul_lo;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_hi, div_lo;

  assign busy      = (state == S_MULT) || (state == S_DIVD);
  assign state_dbg = state;
  assign last      = (cnt == SHW'(WIDTH - 1));

  // magnitudes. The magnitude of MIN is 2^(WIDTH-1), which still fits unsigned.
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // ---------------------------------------------------------------------------
  // single-cycle ALU
  // ---------------------------------------------------------------------------
  assign amt = b[SHW-1:0];

  always_comb begin
    dbl      = {a, a};
    rol_full = dbl << amt;
    ror_full = dbl >> amt;
    alu_val  = a;
    alu_ok   = 1'b1;
    case (op)
      OP_ADD:  alu_val = a + b;
      OP_SUB:  alu_val = a - b;
      OP_SHR:  alu_val = a >> amt;
      OP_SHRA: alu_val = $signed(a) >>> amt;
      OP_SHL:  alu_val = a << amt;
      OP_ROR:  alu_val = ror_full[WIDTH-1:0];
      OP_ROL:  alu_val = rol_full[2*WIDTH-1:WIDTH];
      OP_AND:  alu_val = a & b;
      OP_OR:   alu_val = a | b;
      OP_NEG:  alu_val = -b;
      OP_NOT:  alu_val = ~b;
      default: alu_ok  = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // one iteration step of each multicycle op
  // ---------------------------------------------------------------------------
  always_comb begin
    // shift-add: add the multiplicand when the multiplier LSB is set, then
    // shift {carry, hi, lo} right by one
    mul_add = work_lo[0] ? {1'b0, opnd} : '0;
    mul_sum = {1'b0, work_hi} + mul_add;
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], work_lo[WIDTH-1:1]};
    prod_fin = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};

    // restoring: bring the next dividend bit into the remainder and subtract
    // the divisor if it fits
    div_sh   = {work_hi, work_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_ge   = (div_sh >= {1'b0, opnd});
    div_hi   = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_lo   = {work_lo[WIDTH-2:0], div_ge};
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && !inc_pc) begin
          if (op == OP_MUL)                    state_next = S_MULT;
          else if (op == OP_DIV && b != '0)    state_next = S_DIVD;
        end
      end
      S_MULT, S_DIVD: begin
        if (last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      result   <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      illegal  <= 1'b0;
      cnt      <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
            illegal  <= 1'b0;
            cnt      <= '0;
            if (inc_pc) begin
              result <= a + WIDTH'(PC_INC);
              done   <= 1'b1;
            end else if (op == OP_MUL) begin
              opnd    <= a_mag;
              work_lo <= b_mag;
              work_hi <= '0;
              neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_r   <= 1'b0;
            end else if (op == OP_DIV) begin
              if (b == '0) begin
                div_zero <= 1'b1;
                done     <= 1'b1;
              end else begin
                opnd    <= b_mag;
                work_lo <= a_mag;
                work_hi <= '0;
                neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                neg_r   <= a[WIDTH-1];
              end
            end else begin
              if (alu_ok) result  <= alu_val;
              else        illegal <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        S_MULT: begin
          work_hi <= mul_hi;
          work_lo <= mul_lo;
          cnt     <= cnt + 1'b1;
          if (last) begin
            {hi, lo} <= prod_fin;
            done     <= 1'b1;
          end
        end
        S_DIVD: begin
          work_hi <= div_hi;
          work_lo <= div_lo;
          cnt     <= cnt + 1'b1;
          if (last) begin
            // MIN / -1: the magnitude 2^(WIDTH-1) negates back to MIN, which wraps
            lo   <= neg_q ? -div_lo : div_lo;
            hi   <= neg_r ? -div_hi : div_hi;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc -- testbench for alu_mc. It has a WIDTH=32 instance for the directed
// vector table and the multicycle corner cases. It has a WIDTH=8 instance for
// MUL/DIV against a reference model written with integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_mc;

  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_SHR  = 5'h05;
  localparam logic [4:0] OP_SHRA = 5'h06;
  localparam logic [4:0] OP_SHL  = 5'h07;
  localparam logic [4:0] OP_ROR  = 5'h08;
  localparam logic [4:0] OP_ROL  = 5'h09;
  localparam logic [4:0] OP_AND  = 5'h0A;
  localparam logic [4:0] OP_OR   = 5'h0B;
  localparam logic [4:0] OP_MUL  = 5'h0F;
  localparam logic [4:0] OP_DIV  = 5'h10;
  localparam logic [4:0] OP_NEG  = 5'h11;
  localparam logic [4:0] OP_NOT  = 5'h12;

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic clear;

  // WIDTH=32 instance
  logic        start, inc_pc, busy, done, div_zero, illegal;
  logic [4:0]  op;
  logic [31:0] a, b, result, hi, lo;
  logic [1:0]  state_dbg;

  alu_mc #(.WIDTH(32), .PC_INC(4)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .inc_pc(inc_pc),
    .a(a), .b(b), .result(result), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_zero(div_zero), .illegal(illegal), .state_dbg(state_dbg)
  );

  // WIDTH=8 instance
  logic       start8, inc_pc8, busy8, done8, div_zero8, illegal8;
  logic [4:0] op8;
  logic [7:0] a8, b8, result8, hi8, lo8;
  logic [1:0] state_dbg8;

  alu_mc #(.WIDTH(8), .PC_INC(4)) dut8 (
    .clock(clock), .clear(clear), .start(start8), .op(op8), .inc_pc(inc_pc8),
    .a(a8), .b(b8), .result(result8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8),
    .div_zero(div_zero8), .illegal(illegal8), .state_dbg(state_dbg8)
  );

  // ---------------------------------------------------------------------------
  // scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no done within cycle budget", name);
  endtask

  // ---------------------------------------------------------------------------
  // driver tasks. Both are entered 1 ns after a rising edge and return 1 ns after
  // the edge that produced done. lat counts edges from the accept edge
  // (accept edge = 1). bcnt counts samples with busy high.
  // ---------------------------------------------------------------------------
  task automatic run32(input logic [4:0] o, input logic inc, input logic [31:0] aa,
                       input logic [31:0] bb, output int lat, output int bcnt);
    op = o; inc_pc = inc; a = aa; b = bb; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; inc_pc = 1'b0;
    lat = 1; bcnt = 0;
    forever begin
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) break;
      if (lat >= 100) begin timeout_fail("run32_done"); break; end
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic run8(input logic [4:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      output int lat);
    op8 = o; a8 = aa; b8 = bb; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    lat = 1;
    forever begin
      if (done8 === 1'b1) break;
      if (lat >= 100) begin timeout_fail("run8_done"); break; end
      @(posedge clock); #1;
      lat++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0]  op;
    logic        inc;
    logic [31:0] a, b, res, hi, lo;
    logic        dz, ill;
    int          lat, bsy;
  } vec_t;

  vec_t vt[$];

  task automatic add_v(input logic [4:0] o, input logic inc, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [31:0] r, input logic [31:0] h,
                       input logic [31:0] l, input logic dz, input logic ill);
    vec_t v;
    logic multi;
    multi   = !inc && (o == OP_MUL || (o == OP_DIV && bb != 32'h0));
    v.op = o; v.inc = inc; v.a = aa; v.b = bb;
    v.res = r; v.hi = h; v.lo = l; v.dz = dz; v.ill = ill;
    v.lat = multi ? 33 : 1;
    v.bsy = multi ? 32 : 0;
    vt.push_back(v);
  endtask

  // ---------------------------------------------------------------------------
  // watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat, bcnt, ndone, nbusy, done_at;
    int vals[8];
    logic [31:0] res_before;
    logic [7:0]  prev_hi8, prev_lo8;
    logic [15:0] e16;

    start = 0; inc_pc = 0; op = '0; a = '0; b = '0;
    start8 = 0; inc_pc8 = 0; op8 = '0; a8 = '0; b8 = '0;
    clear = 1'b0;

    // -- reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_result", result, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_illegal", illegal, 0);
    check("rst_state", state_dbg, 0);
    check("rst8_hilo", {hi8, lo8}, 0);
    clear = 1'b1;
    @(posedge clock); #1;

    // -- directed table (hi/lo/result carry over from one vector to the next)
    //      op       inc   a             b             result        hi            lo            dz ill
    add_v(OP_ADD,  1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        32'h0,        0, 0);
    add_v(OP_SUB,  1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0,        32'h0,        0, 0);
    add_v(OP_ROL,  1'b0, 32'h80000001, 32'd33,       32'h00000003, 32'h0,        32'h0,        0, 0);
    add_v(OP_ROR,  1'b0, 32'h00000003, 32'd1,        32'h80000001, 32'h0,        32'h0,        0, 0);
    add_v(OP_SHRA, 1'b0, 32'h80000000, 32'd4,        32'hF8000000, 32'h0,        32'h0,        0, 0);
    add_v(OP_SHR,  1'b0, 32'h80000000, 32'd4,        32'h08000000, 32'h0,        32'h0,        0, 0);
    add_v(OP_SHL,  1'b0, 32'h00000001, 32'd31,       32'h80000000, 32'h0,        32'h0,        0, 0);
    add_v(OP_SHL,  1'b0, 32'h12345678, 32'd32,       32'h12345678, 32'h0,        32'h0,        0, 0);
    add_v(OP_SHRA, 1'b0, 32'h87654321, 32'd0,        32'h87654321, 32'h0,        32'h0,        0, 0);
    add_v(OP_AND,  1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0,        32'h0,        0, 0);
    add_v(OP_OR,   1'b0, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 32'h0,        32'h0,        0, 0);
    add_v(OP_NEG,  1'b0, 32'h00000055, 32'h00000001, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 0);
    add_v(OP_NOT,  1'b0, 32'h00000000, 32'h0000FFFF, 32'hFFFF0000, 32'h0,        32'h0,        0, 0);
    add_v(OP_MUL,  1'b1, 32'h00000100, 32'h00000003, 32'h00000104, 32'h0,        32'h0,        0, 0);
    add_v(OP_MUL,  1'b0, 32'hFFFFFFFD, 32'h00000007, 32'h00000104, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
    add_v(5'h1F,   1'b0, 32'h00000001, 32'h00000002, 32'h00000104, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 1);
    add_v(OP_ADD,  1'b0, 32'h00000001, 32'h00000002, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
    add_v(OP_MUL,  1'b0, 32'h80000000, 32'h80000000, 32'h00000003, 32'h40000000, 32'h00000000, 0, 0);
    add_v(OP_DIV,  1'b0, 32'hFFFFFFF9, 32'h00000002, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
    add_v(OP_DIV,  1'b0, 32'h00000005, 32'h00000000, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 0);
    add_v(OP_DIV,  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000003, 32'h00000000, 32'h80000000, 0, 0);
    add_v(OP_DIV,  1'b0, 32'h00000007, 32'hFFFFFFFE, 32'h00000003, 32'h00000001, 32'hFFFFFFFD, 0, 0);
    add_v(OP_MUL,  1'b0, 32'h7FFFFFFF, 32'h80000000, 32'h00000003, 32'hC0000000, 32'h80000000, 0, 0);
    add_v(5'h0E,   1'b0, 32'h00000009, 32'h00000009, 32'h00000003, 32'hC0000000, 32'h80000000, 0, 1);
    add_v(OP_SUB,  1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'hC0000000, 32'h80000000, 0, 0);

    foreach (vt[i]) begin
      run32(vt[i].op, vt[i].inc, vt[i].a, vt[i].b, lat, bcnt);
      check($sformatf("v%0d_result", i),   result,   vt[i].res);
      check($sformatf("v%0d_hi", i),       hi,       vt[i].hi);
      check($sformatf("v%0d_lo", i),       lo,       vt[i].lo);
      check($sformatf("v%0d_div_zero", i), div_zero, vt[i].dz);
      check($sformatf("v%0d_illegal", i),  illegal,  vt[i].ill);
      check($sformatf("v%0d_latency", i),  lat,      vt[i].lat);
      check($sformatf("v%0d_busy_cyc", i), bcnt,     vt[i].bsy);
      @(posedge clock); #1;
      check($sformatf("v%0d_done_pulse", i), done, 0);
    end
    res_before = vt[vt.size()-1].res;

    // -- start while busy during DIV is ignored: exactly one done at accept+33
    op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    ndone = 0; done_at = 0;
    for (int k = 1; k <= 50; k++) begin
      if (done === 1'b1) begin ndone++; done_at = k; end
      if (k == 5) begin op = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1; end
      if (k == 6) start = 1'b0;
      @(posedge clock); #1;
    end
    check("busy_start_ndone", ndone, 1);
    check("busy_start_done_at", done_at, 33);
    check("busy_start_lo", lo, 32'd14);
    check("busy_start_hi", hi, 32'd2);
    check("busy_start_result", result, res_before);

    // -- back-to-back: start in the MUL done cycle is accepted
    run32(OP_MUL, 1'b0, 32'd6, 32'd7, lat, bcnt);
    check("b2b_mul_lo", lo, 32'd42);
    check("b2b_mul_hi", hi, 32'd0);
    check("b2b_mul_lat", lat, 33);
    run32(OP_ADD, 1'b0, 32'd10, 32'd20, lat, bcnt);
    check("b2b_add_lat", lat, 1);
    check("b2b_add_result", result, 32'd30);
    check("b2b_add_hi", hi, 32'd0);
    check("b2b_add_lo", lo, 32'd42);
    @(posedge clock); #1;

    // -- WIDTH=8 MUL/DIV against integer reference model
    vals = '{-128, -127, -7, -1, 0, 1, 5, 127};
    prev_hi8 = 8'h0; prev_lo8 = 8'h0;
    foreach (vals[i]) begin
      foreach (vals[j]) begin
        e16 = 16'(vals[i] * vals[j]);
        exp_q.push_back(e16);
        run8(OP_MUL, 8'(vals[i]), 8'(vals[j]), lat);
        e16 = exp_q.pop_front();
        check($sformatf("w8_mul_%0d_%0d", vals[i], vals[j]), {hi8, lo8}, e16);
        check($sformatf("w8_mul_lat_%0d_%0d", vals[i], vals[j]), lat, 9);
        prev_hi8 = e16[15:8]; prev_lo8 = e16[7:0];

        if (vals[j] == 0) e16 = {prev_hi8, prev_lo8};
        else e16 = {8'(vals[i] % vals[j]), 8'(vals[i] / vals[j])};
        exp_q.push_back(e16);
        run8(OP_DIV, 8'(vals[i]), 8'(vals[j]), lat);
        e16 = exp_q.pop_front();
        check($sformatf("w8_div_%0d_%0d", vals[i], vals[j]), {hi8, lo8}, e16);
        check($sformatf("w8_div_dz_%0d_%0d", vals[i], vals[j]), div_zero8, (vals[j] == 0));
        check($sformatf("w8_div_lat_%0d_%0d", vals[i], vals[j]), lat, (vals[j] == 0) ? 1 : 9);
        prev_hi8 = e16[15:8]; prev_lo8 = e16[7:0];
      end
    end
    @(posedge clock); #1;

    // -- reset in the middle of a MUL
    op = OP_MUL; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    check("midrst_busy_before", busy, 1);
    clear = 1'b0;
    #1;
    check("midrst_result", result, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_state", state_dbg, 0);
    #2;
    clear = 1'b1;
    nbusy = 0; ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (busy !== 1'b0) nbusy++;
      if (done !== 1'b0) ndone++;
    end
    check("midrst_after_busy", nbusy, 0);
    check("midrst_after_done", ndone, 0);
    check("midrst_after_hilo", {hi, lo}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
